bus_arbiter: RTL and testbench

Multi-master arbiter for the shared system bus in multi-core builds. Each core's `RISC_V_` top exposes one bus master port (ack, rd_data, bus_en, wr_en, wr_data, addr, byte_en). This block sits directly downstream of those ports. It grants one master at a time, round-robin, and forwards that master's transaction to the single memory/peripheral slave port. Atomic sequences (LR/SC, AMO read-modify-write) hold the grant until the master releases it.

---
 rtl/arvi_bus_pkg.sv | 23 ++
 rtl/rr_picker.sv | 38 +++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arvi_bus_pkg
// Description : Shared types and bus field widths for the system bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arvi_bus_pkg;

  // Core data/address width; matches the XLEN of the RISC-V cores on the bus.
  localparam int XLEN = 32;
  // Byte-lane enable width of one bus word.
  localparam int BE_W = 4;

  // Arbiter ownership phases: free, transfer in flight, or bus held by an
  // atomic sequence between transfers.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin selector. Searches the request
//               vector starting at last+1 (mod N) and returns the first hit.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
  import arvi_bus_pkg::*;
#(
  parameter  int N_MASTERS = 2,
  localparam int GNT_W     = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [GNT_W-1:0]     i_last,
  output logic [GNT_W-1:0]     o_gnt,
  output logic                 o_valid
);

  logic [GNT_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester after
  // last is the final (winning) assignment.
  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    cand    = '0;
    for (int off = N_MASTERS; off >= 1; off--) begin
      cand = GNT_W'((int'(i_last) + off) % N_MASTERS);
      if (i_req[cand]) begin
        o_gnt   = cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin multi-master arbiter for the shared system bus.
//               Forwards the granted master to the single slave port and
//               holds the grant across atomic (LR/SC, AMO) sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import arvi_bus_pkg::*;
#(
  parameter  int N_MASTERS = 2,
  localparam int GNT_W     = $clog2(N_MASTERS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_MASTERS-1:0]      i_m_bus_en,
  input  logic [N_MASTERS-1:0]      i_m_wr_en,
  input  logic [N_MASTERS*XLEN-1:0] i_m_wr_data,
  input  logic [N_MASTERS*XLEN-1:0] i_m_addr,
  input  logic [N_MASTERS*BE_W-1:0] i_m_byte_en,
  input  logic [N_MASTERS-1:0]      i_m_atomic,
  output logic [N_MASTERS-1:0]      o_m_ack,
  output logic [XLEN-1:0]           o_m_rd_data,
  output logic                      o_s_bus_en,
  output logic                      o_s_wr_en,
  output logic [XLEN-1:0]           o_s_wr_data,
  output logic [XLEN-1:0]           o_s_addr,
  output logic [BE_W-1:0]           o_s_byte_en,
  input  logic                      i_s_ack,
  input  logic [XLEN-1:0]           i_s_rd_data
);

  arb_state_t       state_q, state_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic [GNT_W-1:0] last_q, last_d;
  logic [GNT_W-1:0] pick_gnt;
  logic             pick_valid;

  logic [XLEN-1:0]  m_wr_data [N_MASTERS];
  logic [XLEN-1:0]  m_addr    [N_MASTERS];
  logic [BE_W-1:0]  m_byte_en [N_MASTERS];

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
    assign m_wr_data[k] = i_m_wr_data[k*XLEN +: XLEN];
    assign m_addr[k]    = i_m_addr[k*XLEN +: XLEN];
    assign m_byte_en[k] = i_m_byte_en[k*BE_W +: BE_W];
  end

  rr_picker #(
    .N_MASTERS (N_MASTERS)
  ) u_rr_picker (
    .i_req   (i_m_bus_en),
    .i_last  (last_q),
    .o_gnt   (pick_gnt),
    .o_valid (pick_valid)
  );

  // Next-state logic: arbitrate only from IDLE; a lock keeps the same master.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          gnt_d   = pick_gnt;
          last_d  = pick_gnt;
        end
      end
      BUSY: begin
        // A master dropping bus_en early does not end the transfer; only the
        // slave ack does.
        if (i_s_ack) begin
          state_d = i_m_atomic[gnt_q] ? LOCKED : IDLE;
        end
      end
      LOCKED: begin
        if (i_m_bus_en[gnt_q]) begin
          state_d = BUSY;
        end else if (!i_m_atomic[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and grant registers; master 0 wins the first arbitration after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GNT_W'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Slave-side mux and ack demux; slave acks outside BUSY are ignored.
  always_comb begin
    o_s_bus_en  = 1'b0;
    o_s_wr_en   = 1'b0;
    o_s_wr_data = '0;
    o_s_addr    = '0;
    o_s_byte_en = '0;
    o_m_ack     = '0;
    if (state_q != IDLE) begin
      o_s_bus_en  = (state_q == BUSY) ? 1'b1 : i_m_bus_en[gnt_q];
      o_s_wr_en   = i_m_wr_en[gnt_q];
      o_s_wr_data = m_wr_data[gnt_q];
      o_s_addr    = m_addr[gnt_q];
      o_s_byte_en = m_byte_en[gnt_q];
    end
    if ((state_q == BUSY) && i_s_ack) begin
      o_m_ack[gnt_q] = 1'b1;
    end
  end

  assign o_m_rd_data = i_s_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter (4 masters). Directed
//               scenarios plus a randomized phase, all compared per cycle
//               against an ownership-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              i_rst;
  logic [N-1:0]      i_m_bus_en, i_m_wr_en, i_m_atomic;
  logic [N*32-1:0]   i_m_wr_data, i_m_addr;
  logic [N*4-1:0]    i_m_byte_en;
  logic [N-1:0]      o_m_ack;
  logic [31:0]       o_m_rd_data;
  logic              o_s_bus_en, o_s_wr_en;
  logic [31:0]       o_s_wr_data, o_s_addr;
  logic [3:0]        o_s_byte_en;
  logic              i_s_ack;
  logic [31:0]       i_s_rd_data;

  always #5 clk = ~clk;

  bus_arbiter #(.N_MASTERS(N)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_m_bus_en(i_m_bus_en), .i_m_wr_en(i_m_wr_en), .i_m_wr_data(i_m_wr_data),
    .i_m_addr(i_m_addr), .i_m_byte_en(i_m_byte_en), .i_m_atomic(i_m_atomic),
    .o_m_ack(o_m_ack), .o_m_rd_data(o_m_rd_data),
    .o_s_bus_en(o_s_bus_en), .o_s_wr_en(o_s_wr_en), .o_s_wr_data(o_s_wr_data),
    .o_s_addr(o_s_addr), .o_s_byte_en(o_s_byte_en),
    .i_s_ack(i_s_ack), .i_s_rd_data(i_s_rd_data)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic [31:0] f32(input logic [N*32-1:0] v, input int i);
    logic [N*32-1:0] s;
    s = v >> (i * 32);
    return s[31:0];
  endfunction

  function automatic logic [3:0] f4(input logic [N*4-1:0] v, input int i);
    logic [N*4-1:0] s;
    s = v >> (i * 4);
    return s[3:0];
  endfunction

  // ---------------- reference model: who owns the bus, is a transfer open
  int md_own;     // -1 when the bus is free
  bit md_flight;  // transfer open (slave ack will complete it)
  int md_last;    // most recent grant

  task automatic model_reset();
    md_own = -1; md_flight = 0; md_last = N - 1;
  endtask

  function automatic int rr_pick();
    int c;
    for (int off = 1; off <= N; off++) begin
      c = (md_last + off) % N;
      if (bitof(i_m_bus_en, c)) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    int p;
    if (i_rst) model_reset();
    else if (md_own < 0) begin
      p = rr_pick();
      if (p >= 0) begin md_own = p; md_flight = 1; md_last = p; end
    end else if (md_flight) begin
      if (i_s_ack) begin
        md_flight = 0;
        if (!bitof(i_m_atomic, md_own)) md_own = -1;
      end
    end else begin
      if (bitof(i_m_bus_en, md_own)) md_flight = 1;
      else if (!bitof(i_m_atomic, md_own)) md_own = -1;
    end
  endtask

  // ---------------- master agents (scripted transaction queues)
  typedef struct {
    logic [31:0] addr; logic [31:0] data; logic we; logic [3:0] be;
    logic atomic; int gap;
  } txn_t;

  txn_t         mq [N][$];
  bit           m_active   [N];
  int           m_gapc     [N];
  bit           m_lockhold [N];
  logic [N-1:0] exp_ack_prev;

  int           ack_order [$];
  logic [31:0]  ack_addr  [$];
  logic [31:0]  ack_rd    [$];
  int           ack_cyc   [$];

  // ---------------- slave agent
  int          s_mode;   // 0 manual, 1 fixed delay, 2 random
  int          s_delay;
  int          s_wait;
  logic [31:0] s_fixed_rd;
  bit          man_ack;
  bit          rst_req;

  task automatic push(input int k, input logic [31:0] a, input logic we,
                      input logic at, input int gap);
    txn_t t;
    t.addr = a; t.data = $urandom; t.we = we; t.be = 4'($urandom | 1);
    t.atomic = at; t.gap = gap;
    mq[k].push_back(t);
  endtask

  task automatic clear_masters();
    for (int k = 0; k < N; k++) begin
      mq[k].delete(); m_active[k] = 0; m_gapc[k] = 0; m_lockhold[k] = 0;
    end
    exp_ack_prev = '0;
  endtask

  task automatic clear_log();
    ack_order.delete(); ack_addr.delete(); ack_rd.delete(); ack_cyc.delete();
  endtask

  task automatic drive_masters();
    logic [N-1:0] en, we, at;
    logic [N*32-1:0] a, d;
    logic [N*4-1:0] b;
    txn_t t;
    en = '0; we = '0; at = '0; a = '0; d = '0; b = '0;
    for (int k = 0; k < N; k++) begin
      if (m_active[k] && bitof(exp_ack_prev, k)) begin
        t = mq[k].pop_front();
        m_active[k] = 0; m_gapc[k] = 0;
        m_lockhold[k] = t.atomic && (mq[k].size() > 0) && mq[k][0].atomic;
      end
      if (!m_active[k] && mq[k].size() > 0) begin
        if (m_gapc[k] >= mq[k][0].gap) m_active[k] = 1;
        else m_gapc[k]++;
      end
      if (m_active[k]) begin
        t = mq[k][0];
        en = en | (N'(1) << k);
        if (t.we) we = we | (N'(1) << k);
        if (t.atomic) at = at | (N'(1) << k);
        a = a | ((N*32)'(t.addr) << (k * 32));
        d = d | ((N*32)'(t.data) << (k * 32));
        b = b | ((N*4)'(t.be) << (k * 4));
      end else begin
        // idle masters wiggle their fields; they must never leak to the slave
        if ($urandom_range(0, 1) == 1) we = we | (N'(1) << k);
        if (m_lockhold[k]) at = at | (N'(1) << k);
        a = a | ((N*32)'($urandom) << (k * 32));
        d = d | ((N*32)'($urandom) << (k * 32));
        b = b | ((N*4)'($urandom_range(0, 15)) << (k * 4));
      end
    end
    i_m_bus_en = en; i_m_wr_en = we; i_m_atomic = at;
    i_m_addr = a; i_m_wr_data = d; i_m_byte_en = b;
  endtask

  task automatic drive_slave();
    i_s_rd_data = $urandom;
    if (s_mode == 0) i_s_ack = man_ack;
    else if (md_flight) begin
      if (s_wait >= s_delay) begin
        i_s_ack = 1'b1; s_wait = 0;
        if (s_mode == 1) i_s_rd_data = s_fixed_rd;
        else s_delay = $urandom_range(0, 3);
      end else begin
        i_s_ack = 1'b0; s_wait++;
      end
    end else begin
      s_wait = 0;
      i_s_ack = (s_mode == 2) && ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] ea;
    logic es, ewe;
    logic [31:0] eaddr, edata;
    logic [3:0] ebe;
    @(negedge clk);
    cyc++;
    ea = '0; es = 0; ewe = 0; eaddr = '0; edata = '0; ebe = '0;
    if (md_own >= 0) begin
      es    = md_flight || bitof(i_m_bus_en, md_own);
      ewe   = bitof(i_m_wr_en, md_own);
      eaddr = f32(i_m_addr, md_own);
      edata = f32(i_m_wr_data, md_own);
      ebe   = f4(i_m_byte_en, md_own);
      if (md_flight && i_s_ack) ea = N'(1) << md_own;
    end
    check("s_bus_en",  32'(o_s_bus_en),  32'(es));
    check("s_wr_en",   32'(o_s_wr_en),   32'(ewe));
    check("s_addr",    o_s_addr,         eaddr);
    check("s_wr_data", o_s_wr_data,      edata);
    check("s_byte_en", 32'(o_s_byte_en), 32'(ebe));
    check("m_ack",     32'(o_m_ack),     32'(ea));
    if (ea != '0) check("m_rd_data", o_m_rd_data, i_s_rd_data);
    for (int k = 0; k < N; k++) begin
      if (bitof(o_m_ack, k)) begin
        ack_order.push_back(k); ack_addr.push_back(o_s_addr);
        ack_rd.push_back(o_m_rd_data); ack_cyc.push_back(cyc);
      end
    end
    exp_ack_prev = ea;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    i_rst = rst_req;
    if (i_rst) model_reset();
    drive_masters();
    #1;
    drive_slave();
    check_cycle();
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (mq[k].size() > 0 || m_active[k]) return 1;
    return md_own >= 0;
  endfunction

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin step(); n++; end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    clear_masters();
    s_mode = 0; man_ack = 0; s_wait = 0;
    rst_req = 1; step(); step();
    rst_req = 0; step();
    clear_log();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    int len;
    i_rst = 1; rst_req = 1;
    i_m_bus_en = '0; i_m_wr_en = '0; i_m_atomic = '0;
    i_m_addr = '0; i_m_wr_data = '0; i_m_byte_en = '0;
    i_s_ack = 0; i_s_rd_data = '0;
    s_mode = 0; s_delay = 0; s_wait = 0; s_fixed_rd = '0; man_ack = 0;
    clear_masters(); clear_log(); model_reset();
    #1;
    check("rst_s_bus_en", 32'(o_s_bus_en), 32'd0);
    check("rst_s_addr",   o_s_addr,        32'd0);
    check("rst_m_ack",    32'(o_m_ack),    32'd0);
    do_reset();

    // master 0 single read, slave answers after two wait cycles
    s_mode = 1; s_delay = 2; s_fixed_rd = 32'hDEADBEEF;
    push(0, 32'h100, 1'b0, 1'b0, 0);
    step();
    check("t1_req_cycle", 32'(o_s_bus_en), 32'd0);
    step();
    check("t1_grant_next", 32'(o_s_bus_en), 32'd1);
    run_until_idle("t1_drain", 50);
    check("t1_n_acks", 32'(ack_order.size()), 32'd1);
    if (ack_order.size() == 1) begin
      check("t1_ack_master", 32'(ack_order[0]), 32'd0);
      check("t1_ack_addr",   ack_addr[0],       32'h100);
      check("t1_rd_data",    ack_rd[0],         32'hDEADBEEF);
    end

    // simultaneous writes from masters 0 and 1, zero-wait slave
    do_reset();
    s_mode = 1; s_delay = 0;
    push(0, 32'h10, 1'b1, 1'b0, 0);
    push(1, 32'h20, 1'b1, 1'b0, 0);
    run_until_idle("t2_drain", 50);
    check("t2_n_acks", 32'(ack_order.size()), 32'd2);
    if (ack_order.size() == 2) begin
      check("t2_first_addr",  ack_addr[0], 32'h10);
      check("t2_second_addr", ack_addr[1], 32'h20);
      check("t2_idle_gap",    32'(ack_cyc[1] - ack_cyc[0]), 32'd2);
    end

    // all four masters request continuously: strict rotation
    do_reset();
    s_mode = 1; s_delay = 0;
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < N; k++) push(k, 32'h1000 + 32'(k * 256 + j * 4), 1'b0, 1'b0, 0);
    run_until_idle("t3_drain", 200);
    check("t3_n_acks", 32'(ack_order.size()), 32'd12);
    if (ack_order.size() == 12)
      for (int i = 0; i < 12; i++) check("t3_rr_order", 32'(ack_order[i]), 32'(i % N));

    // master 1 atomic read+write to 0x40 while master 0 waits
    do_reset();
    s_mode = 1; s_delay = 1;
    push(1, 32'h40, 1'b0, 1'b1, 0);
    push(1, 32'h40, 1'b1, 1'b1, 1);
    push(0, 32'h80, 1'b0, 1'b0, 1);
    run_until_idle("t4_drain", 100);
    check("t4_n_acks", 32'(ack_order.size()), 32'd3);
    if (ack_order.size() == 3) begin
      check("t4_lock_0", 32'(ack_order[0]), 32'd1);
      check("t4_lock_1", 32'(ack_order[1]), 32'd1);
      check("t4_after",  32'(ack_order[2]), 32'd0);
      check("t4_addr",   ack_addr[2],       32'h80);
    end

    // asynchronous reset while BUSY, then stray ack, then a fresh request
    do_reset();
    s_mode = 0; man_ack = 0;
    push(0, 32'h200, 1'b0, 1'b0, 0);
    step(); step();
    check("t5_busy", 32'(o_s_bus_en), 32'd1);
    #2;
    i_rst = 1;
    #1;
    check("t5_async_bus_en", 32'(o_s_bus_en), 32'd0);
    check("t5_async_addr",   o_s_addr,        32'd0);
    i_s_ack = 1;
    #1;
    check("t5_ack_in_rst", 32'(o_m_ack), 32'd0);
    model_reset(); clear_masters();
    rst_req = 1; man_ack = 1; step();
    rst_req = 0; step(); step();
    man_ack = 0;
    clear_log();
    s_mode = 1; s_delay = 1;
    push(0, 32'h200, 1'b0, 1'b0, 0);
    run_until_idle("t5_drain", 50);
    check("t5_n_acks", 32'(ack_order.size()), 32'd1);

    // slave ack while IDLE is ignored
    do_reset();
    s_mode = 0; man_ack = 1;
    step(); step();
    check("t6_idle_ack", 32'(o_m_ack), 32'd0);
    man_ack = 0;
    step();
    check("t6_still_idle", 32'(o_s_bus_en), 32'd0);

    // randomized traffic, atomic sequences, spurious slave acks
    do_reset();
    s_mode = 2; s_delay = 1;
    total = 0;
    for (int k = 0; k < N; k++) begin
      int cnt;
      cnt = 0;
      while (cnt < 10) begin
        if ($urandom_range(0, 3) == 0) begin
          len = $urandom_range(2, 3);
          for (int j = 0; j < len; j++)
            push(k, $urandom, 1'($urandom_range(0, 1)), 1'b1, (j == 0) ? $urandom_range(0, 3) : $urandom_range(0, 2));
        end else begin
          len = 1;
          push(k, $urandom, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3));
        end
        cnt += len;
      end
      total += cnt;
    end
    run_until_idle("rand_drain", 4000);
    check("rand_n_acks", 32'(ack_order.size()), 32'(total));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
